escalonador_round_robin: RTL and testbench
==========================================

Name: escalonador_round_robin

Overview:
- Round-robin scheduler that shares one resource between four requesters. Only one requester is granted at a time.
- Priority comes from a rotating one-hot pointer (0001 -> 0010 -> 0100 -> 1000 -> 0001). This is the same ring sequence the team's one-hot counters use.
- Each grant is limited to a quantum of QUANTUM cycles, so a requester that holds the resource cannot starve the others.
- Sits between the requesting units and the shared datapath. concessao drives the datapath's select/enable.

Parameters:
- QUANTUM, 4, maximum consecutive cycles one grant may last; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request lines; req[i] high = requester i wants or keeps the resource.
- concessao  output  4  one-hot grant; 0000 when nothing is granted.
- id_concessao  output  2  binary index of the granted requester; 0 when nothing is granted.
- ocupado  output  1  high while any grant is active (equals |concessao).
- ponteiro  output  4  current one-hot priority pointer.
- expirou  output  1  one-cycle pulse: the last grant was cut off by the quantum.

Behaviour:
- Reset (asynchronous, immediate, also mid-grant):
  - concessao=0000, id_concessao=0, ocupado=0, expirou=0.
  - ponteiro=0001, state=OCIOSO, cycle counter=0.
- All outputs are registered. There is no combinational path from req to any output.
- States: OCIOSO, CONCEDIDO, INTERVALO.
- Arbitration (performed on an edge in OCIOSO or INTERVALO when req!=0000):
  - Search starts at the ponteiro position and goes ascending with wrap 3->0.
  - The first requester with req high wins.
  - concessao becomes that bit, counter=1, state=CONCEDIDO.
  - Latency: grant is visible the cycle after req is first sampled high.
- OCIOSO: req==0000 -> stay; else arbitrate.
- CONCEDIDO, on each edge, with g = granted index:
  - req[g]==0 -> release.
  - counter==QUANTUM with req[g]==1 -> forced release.
  - Otherwise counter+1 and the grant holds. Changes on other req bits are ignored.
- Release (either cause):
  - concessao=0000, state=INTERVALO.
  - ponteiro = rotate-left of concessao, so the bit after g gets top priority (1000 wraps to 0001).
  - expirou=1 for exactly the INTERVALO cycle, only on a forced release.
- Simultaneous drop of req[g] and counter==QUANTUM -> normal release, expirou=0.
- INTERVALO lasts exactly one cycle (no grant, so the datapath sees a one-cycle gap):
  - Next edge: arbitrate if req!=0000, else go to OCIOSO.
  - expirou returns to 0 on leaving INTERVALO.
- Grant length = min(cycles req[g] held, QUANTUM).
- QUANTUM=1: every grant lasts one cycle, followed by a one-cycle gap.
- Counter is 4 bits and never exceeds QUANTUM.
- ponteiro changes only on release; it stays one-hot at all times.
- A requester that drops req before being granted simply loses its turn; there is no queued memory of requests.

Test Plan:
- Reset, req=0000 for 5 cycles -> concessao=0000, ponteiro=0001, ocupado=0 throughout.
- req=0100 held for 2 cycles then 0000 (QUANTUM=4):
  - concessao=0100 for 2 cycles, then 0000.
  - ponteiro=1000, expirou stays 0.
- req=1111 held constantly (QUANTUM=4):
  - Grants cycle 0001,0010,0100,1000,0001.
  - Each lasts 4 cycles with a 1-cycle gap.
  - expirou pulses in every gap.
  - id_concessao follows 0,1,2,3,0.
- ponteiro=1000 (after a grant to 2), req=0011 -> grant 0001 (wrap 3->0), not 0010.
- Grant to 1 with counter==QUANTUM and req[1] dropping on the same edge -> release with expirou=0; ponteiro=0100.
- reset asserted between clock edges mid-grant:
  - Outputs clear immediately without waiting for an edge; ponteiro=0001.
  - After reset deasserts with req=0010: grant 0010 one cycle later.

Source files
------------

// File: rtl/escalonador_round_robin_if.sv
// Request/grant bundle between the requesting units and the round-robin scheduler.
// The scheduler side takes the master modport; the requesters take the slave modport.
interface escalonador_round_robin_if;
    logic [3:0] req;
    logic [3:0] concessao;
    logic [1:0] id_concessao;
    logic       ocupado;
    logic [3:0] ponteiro;
    logic       expirou;

    modport master (
        input  req,
        output concessao,
        output id_concessao,
        output ocupado,
        output ponteiro,
        output expirou
    );

    modport slave (
        output req,
        input  concessao,
        input  id_concessao,
        input  ocupado,
        input  ponteiro,
        input  expirou
    );
endinterface

// File: rtl/escalonador_round_robin.sv
// Four-way round-robin scheduler with a rotating one-hot pointer and a per-grant quantum.
// Every output is registered; after each release there is a one-cycle gap with no grant.
module escalonador_round_robin #(
    parameter int QUANTUM = 4
) (
    input logic                        clk,
    input logic                        reset,
    escalonador_round_robin_if.master  bus
);
    localparam logic [3:0] LIMITE = 4'(QUANTUM);

    typedef enum logic [1:0] {OCIOSO, CONCEDIDO, INTERVALO} estado_t;

    estado_t    estado, estado_prox;
    logic [3:0] concessao_r, concessao_prox;
    logic [3:0] ponteiro_r, ponteiro_prox;
    logic [3:0] contador, contador_prox;
    logic [1:0] id_r;
    logic       ocupado_r;
    logic       expirou_r, expirou_prox;
    logic [1:0] base, candidato, vencedor;
    logic       achado;

    function automatic logic [1:0] codifica(input logic [3:0] oh);
        logic [1:0] indice;
        case (oh)
            4'b0010: indice = 2'd1;
            4'b0100: indice = 2'd2;
            4'b1000: indice = 2'd3;
            default: indice = 2'd0;
        endcase
        return indice;
    endfunction

    // The search starts at the pointer position and wraps 3 -> 0; the first active request wins.
    always_comb begin
        base      = codifica(ponteiro_r);
        candidato = 2'd0;
        vencedor  = 2'd0;
        achado    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            candidato = base + 2'(k);
            if (!achado && bus.req[candidato]) begin
                achado   = 1'b1;
                vencedor = candidato;
            end
        end
    end

    always_comb begin
        estado_prox    = estado;
        concessao_prox = concessao_r;
        ponteiro_prox  = ponteiro_r;
        contador_prox  = contador;
        expirou_prox   = 1'b0;
        case (estado)
            OCIOSO, INTERVALO: begin
                if (achado) begin
                    concessao_prox = 4'b0001 << vencedor;
                    contador_prox  = 4'd1;
                    estado_prox    = CONCEDIDO;
                end else begin
                    estado_prox    = OCIOSO;
                end
            end
            CONCEDIDO: begin
                // A dropped request takes precedence, so it never counts as a quantum cut.
                if ((bus.req & concessao_r) == 4'b0000 || contador == LIMITE) begin
                    expirou_prox   = ((bus.req & concessao_r) != 4'b0000);
                    concessao_prox = 4'b0000;
                    ponteiro_prox  = {concessao_r[2:0], concessao_r[3]};
                    contador_prox  = 4'd0;
                    estado_prox    = INTERVALO;
                end else begin
                    contador_prox  = contador + 4'd1;
                end
            end
            default: begin
                concessao_prox = 4'b0000;
                contador_prox  = 4'd0;
                estado_prox    = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            concessao_r <= 4'b0000;
            ponteiro_r  <= 4'b0001;
            contador    <= 4'd0;
            id_r        <= 2'd0;
            ocupado_r   <= 1'b0;
            expirou_r   <= 1'b0;
        end else begin
            estado      <= estado_prox;
            concessao_r <= concessao_prox;
            ponteiro_r  <= ponteiro_prox;
            contador    <= contador_prox;
            id_r        <= codifica(concessao_prox);
            ocupado_r   <= |concessao_prox;
            expirou_r   <= expirou_prox;
        end
    end

    assign bus.concessao    = concessao_r;
    assign bus.id_concessao = id_r;
    assign bus.ocupado      = ocupado_r;
    assign bus.ponteiro     = ponteiro_r;
    assign bus.expirou      = expirou_r;
endmodule

// File: tb/tb_escalonador_round_robin.sv
// Scoreboard bench for escalonador_round_robin: a behavioural model pushes expected outputs
// on every clock edge and they are popped and compared just after the edge.
module tb_escalonador_round_robin;
    localparam int QUANTUM = 4;

    logic clk;
    logic reset;

    escalonador_round_robin_if bus();

    escalonador_round_robin #(.QUANTUM(QUANTUM)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [3:0] concessao;
        logic [1:0] id;
        logic       ocupado;
        logic [3:0] ponteiro;
        logic       expirou;
    } esperado_t;

    esperado_t placar[$];
    int        tests_run    = 0;
    int        tests_failed = 0;

    int   modelo_dono;
    int   modelo_ptr;
    int   modelo_tempo;
    logic modelo_exp;
    logic [3:0] req_atual;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [3:0] observado, input logic [3:0] esperado);
        tests_run++;
        if (observado !== esperado) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %b, expected %b", tag, observado, esperado);
        end
    endtask

    task automatic modelReset();
        modelo_dono  = -1;
        modelo_ptr   = 0;
        modelo_tempo = 0;
        modelo_exp   = 1'b0;
    endtask

    // Owner-index model: a grant ends when its owner lets go or has held for QUANTUM cycles.
    task automatic modelStep(input logic [3:0] r);
        modelo_exp = 1'b0;
        if (modelo_dono >= 0) begin
            if (!r[modelo_dono]) begin
                modelo_ptr  = (modelo_dono + 1) % 4;
                modelo_dono = -1;
            end else if (modelo_tempo == QUANTUM) begin
                modelo_ptr  = (modelo_dono + 1) % 4;
                modelo_dono = -1;
                modelo_exp  = 1'b1;
            end else begin
                modelo_tempo++;
            end
        end else if (r != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (modelo_ptr + k) % 4;
                if (modelo_dono < 0 && r[c]) begin
                    modelo_dono  = c;
                    modelo_tempo = 1;
                end
            end
        end
    endtask

    function automatic esperado_t modelOutputs();
        esperado_t e;
        e.concessao = (modelo_dono >= 0) ? (4'b0001 << modelo_dono) : 4'b0000;
        e.id        = (modelo_dono >= 0) ? 2'(modelo_dono) : 2'd0;
        e.ocupado   = (modelo_dono >= 0);
        e.ponteiro  = 4'b0001 << modelo_ptr;
        e.expirou   = modelo_exp;
        return e;
    endfunction

    task automatic compareNext();
        esperado_t e;
        if (placar.size() == 0) begin
            checkOutput("scoreboard_empty", 4'd0, 4'd1);
        end else begin
            e = placar.pop_front();
            checkOutput("concessao",    bus.concessao,            e.concessao);
            checkOutput("id_concessao", {2'b00, bus.id_concessao}, {2'b00, e.id});
            checkOutput("ocupado",      {3'b000, bus.ocupado},     {3'b000, e.ocupado});
            checkOutput("ponteiro",     bus.ponteiro,             e.ponteiro);
            checkOutput("expirou",      {3'b000, bus.expirou},     {3'b000, e.expirou});
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        modelStep(r);
        placar.push_back(modelOutputs());
        #1;
        compareNext();
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b1;
        bus.req = 4'b0000;
        modelReset();
        #12;
        reset = 1'b0;
        checkOutput("reset_concessao", bus.concessao, 4'b0000);
        checkOutput("reset_ponteiro",  bus.ponteiro,  4'b0001);
        checkOutput("reset_ocupado",   {3'b000, bus.ocupado}, 4'd0);
        checkOutput("reset_expirou",   {3'b000, bus.expirou}, 4'd0);

        repeat (5) applyStimulus(4'b0000);

        // All four requesting: five full quantum grants, each followed by an expiry gap.
        repeat (25) applyStimulus(4'b1111);
        checkOutput("full_gap_expirou",  {3'b000, bus.expirou}, 4'd1);
        checkOutput("full_gap_ponteiro", bus.ponteiro, 4'b0010);
        applyStimulus(4'b0000);

        applyStimulus(4'b0100);
        checkOutput("short_grant", bus.concessao, 4'b0100);
        applyStimulus(4'b0100);
        applyStimulus(4'b0000);
        checkOutput("short_ponteiro", bus.ponteiro, 4'b1000);
        checkOutput("short_expirou",  {3'b000, bus.expirou}, 4'd0);
        applyStimulus(4'b0000);

        applyStimulus(4'b0011);
        checkOutput("wrap_grant", bus.concessao, 4'b0001);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        repeat (4) applyStimulus(4'b0010);
        checkOutput("limit_grant", bus.concessao, 4'b0010);
        applyStimulus(4'b0000);
        checkOutput("limit_drop_expirou",  {3'b000, bus.expirou}, 4'd0);
        checkOutput("limit_drop_ponteiro", bus.ponteiro, 4'b0100);
        applyStimulus(4'b0000);

        req_atual = 4'b0000;
        repeat (60) begin
            if ($urandom_range(0, 2) == 0) req_atual = 4'($urandom_range(0, 15));
            applyStimulus(req_atual);
        end

        // Reset asserted between edges while a grant is active.
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);
        applyStimulus(4'b1000);
        applyStimulus(4'b1000);
        checkOutput("pre_reset_grant", bus.concessao, 4'b1000);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_concessao", bus.concessao, 4'b0000);
        checkOutput("async_id",        {2'b00, bus.id_concessao}, 4'd0);
        checkOutput("async_ocupado",   {3'b000, bus.ocupado}, 4'd0);
        checkOutput("async_ponteiro",  bus.ponteiro, 4'b0001);
        modelReset();
        #3;
        reset = 1'b0;
        applyStimulus(4'b0010);
        checkOutput("post_reset_grant", bus.concessao, 4'b0010);
        applyStimulus(4'b0000);
        applyStimulus(4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
